// File: rtl/ext_mem_pkg.sv
// Shared widths and FSM encoding for the external memory model.
package ext_mem_pkg;

    localparam int MEM_DATA_BITS_DEF = 128;
    localparam int MEM_TAG_BITS_DEF  = 5;
    localparam int MEM_ADDR_BITS_DEF = 28;
    localparam int DEPTH_LOG2_DEF    = 16;
    localparam int READ_LATENCY_DEF  = 1;

    // IDLE accepts requests; WDATA waits for the single write-data beat.
    typedef enum logic {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } ext_mem_state_e;

endpackage

// File: rtl/ext_mem_resp_pipe.sv
// Read-response delay line: LATENCY stages of {valid, tag, data}.
// The last stage drives the response outputs directly, so they are registered.
module ext_mem_resp_pipe #(
    parameter int LATENCY   = 1,
    parameter int DATA_BITS = 128,
    parameter int TAG_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [TAG_BITS-1:0]  in_tag,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_valid,
    output logic [TAG_BITS-1:0]  out_tag,
    output logic [DATA_BITS-1:0] out_data
);

    logic                 valid_sr [LATENCY];
    logic [TAG_BITS-1:0]  tag_sr   [LATENCY];
    logic [DATA_BITS-1:0] data_sr  [LATENCY];

    // Shift one stage per cycle; a reset flushes every in-flight response.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_sr[i] <= 1'b0;
                tag_sr[i]   <= '0;
                data_sr[i]  <= '0;
            end
        end else begin
            valid_sr[0] <= in_valid;
            tag_sr[0]   <= in_tag;
            data_sr[0]  <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                tag_sr[i]   <= tag_sr[i-1];
                data_sr[i]  <= data_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[LATENCY-1];
    assign out_tag   = tag_sr[LATENCY-1];
    assign out_data  = data_sr[LATENCY-1];

endmodule

// File: rtl/ext_mem_model.sv
// Line-wide behavioural main memory behind a tagged request / write-data /
// read-response handshake.
//
// Handshake: a request or write-data beat transfers on a rising edge where
// its valid and ready are both high. The requester holds valid and its
// payload stable until that edge. Ready never depends on valid. The
// response channel has no ready: mem_resp_valid pulses for exactly one
// cycle per read, and the consumer must take it.
module ext_mem_model
    import ext_mem_pkg::*;
#(
    parameter int MEM_DATA_BITS = MEM_DATA_BITS_DEF,
    parameter int MEM_TAG_BITS  = MEM_TAG_BITS_DEF,
    parameter int MEM_ADDR_BITS = MEM_ADDR_BITS_DEF,
    parameter int DEPTH_LOG2    = DEPTH_LOG2_DEF,
    parameter int READ_LATENCY  = READ_LATENCY_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_req_valid,
    output logic                       mem_req_ready,
    input  logic                       mem_req_rw,
    input  logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    input  logic [MEM_TAG_BITS-1:0]    mem_req_tag,
    input  logic                       mem_req_data_valid,
    output logic                       mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                       mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   mem_resp_data,
    output logic [MEM_TAG_BITS-1:0]    mem_resp_tag
);

    localparam int MASK_BITS = MEM_DATA_BITS / 8;
    localparam int DEPTH     = 1 << DEPTH_LOG2;

    // Preloaded hierarchically by the harness; never cleared by reset.
    logic [MEM_DATA_BITS-1:0] ram [0:DEPTH-1];

    ext_mem_state_e           state;
    ext_mem_state_e           state_next;
    logic [DEPTH_LOG2-1:0]    req_idx;
    logic [DEPTH_LOG2-1:0]    wr_idx;
    logic                     req_fire;
    logic                     rd_fire;
    logic                     wr_req_fire;
    logic                     data_fire;
    logic [MEM_DATA_BITS-1:0] merged_line;
    logic                     unused_addr_hi;

    // Address bits above the stored depth alias onto the same lines.
    assign req_idx        = mem_req_addr[DEPTH_LOG2-1:0];
    assign unused_addr_hi = ^mem_req_addr[MEM_ADDR_BITS-1:DEPTH_LOG2];

    assign req_fire    = mem_req_valid && mem_req_ready;
    assign rd_fire     = req_fire && !mem_req_rw;
    assign wr_req_fire = req_fire && mem_req_rw;
    assign data_fire   = mem_req_data_valid && mem_req_data_ready;

    // State register; reset abandons any half-finished write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a write request parks us in WDATA until its data beat lands.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wr_req_fire) state_next = WDATA;
            WDATA:   if (data_fire)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ready outputs decoded from state, both forced low while in reset.
    always_comb begin
        mem_req_ready      = 1'b0;
        mem_req_data_ready = 1'b0;
        if (reset) begin
            case (state)
                IDLE:    mem_req_ready      = 1'b1;
                WDATA:   mem_req_data_ready = 1'b1;
                default: ;
            endcase
        end
    end

    // Remember the target line of an accepted write for its later data beat.
    always_ff @(posedge clk) begin
        if (wr_req_fire) begin
            wr_idx <= req_idx;
        end
    end

    // Byte-masked merge of the write beat into the current line contents.
    always_comb begin
        merged_line = ram[wr_idx];
        for (int i = 0; i < MASK_BITS; i++) begin
            if (mem_req_data_mask[i]) begin
                merged_line[8*i +: 8] = mem_req_data_bits[8*i +: 8];
            end
        end
    end

    // Array write on the data beat; an all-zero mask rewrites the line unchanged.
    always_ff @(posedge clk) begin
        if (data_fire) begin
            ram[wr_idx] <= merged_line;
        end
    end

    // Read data is sampled at the accept edge and delayed to the response port.
    ext_mem_resp_pipe #(
        .LATENCY   (READ_LATENCY),
        .DATA_BITS (MEM_DATA_BITS),
        .TAG_BITS  (MEM_TAG_BITS)
    ) u_resp_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_fire),
        .in_tag    (mem_req_tag),
        .in_data   (ram[req_idx]),
        .out_valid (mem_resp_valid),
        .out_tag   (mem_resp_tag),
        .out_data  (mem_resp_data)
    );

endmodule

// File: tb/tb_ext_mem_model.sv
// Randomised bench for ext_mem_model with a line-level memory model and an
// in-order expected-response queue, plus pinned literal scenarios.
module tb_ext_mem_model;

    localparam int DB = 128;
    localparam int TW = 5;
    localparam int AB = 28;
    localparam int DL = 16;
    localparam int RL = 1;
    localparam int MB = DB / 8;
    localparam int EW = 32 + TW + DB;

    localparam logic [DB-1:0] LINE5 = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [DB-1:0] LINE7 = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
    localparam logic [DB-1:0] LINE7_MERGED = 128'ha5a5a5a5a5a5a5a5ffffffffffffffff;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_rw;
    logic [AB-1:0] mem_req_addr;
    logic [TW-1:0] mem_req_tag;
    logic          mem_req_data_valid;
    logic          mem_req_data_ready;
    logic [DB-1:0] mem_req_data_bits;
    logic [MB-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic [DB-1:0] mem_resp_data;
    logic [TW-1:0] mem_resp_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Model: line contents keyed by wrapped line index, one outstanding write.
    logic [DB-1:0] model_mem [int];
    bit            wr_pending = 1'b0;
    int            wr_line;
    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] e;
    bit            exp_rv;
    int            line;
    logic [DB-1:0] cur;

    ext_mem_model dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data),
        .mem_resp_tag       (mem_resp_tag)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: compare outputs after each edge, then advance the model to the next edge.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_rv = 1'b0;
            if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
                exp_rv = 1'b1;
                e = exp_q.pop_front();
            end
            check("resp_valid", DB'(mem_resp_valid), DB'(exp_rv));
            if (exp_rv) begin
                check("resp_tag", DB'(mem_resp_tag), DB'(e[DB +: TW]));
                check("resp_data", mem_resp_data, e[DB-1:0]);
            end
            check("req_ready", DB'(mem_req_ready), DB'(reset && !wr_pending));
            check("data_ready", DB'(mem_req_data_ready), DB'(reset && wr_pending));

            if (!reset) begin
                exp_q.delete();
                wr_pending = 1'b0;
            end else if (wr_pending) begin
                if (mem_req_data_valid) begin
                    cur = model_mem.exists(wr_line) ? model_mem[wr_line] : '0;
                    for (int b = 0; b < MB; b++) begin
                        if (mem_req_data_mask[b]) cur[8*b +: 8] = mem_req_data_bits[8*b +: 8];
                    end
                    model_mem[wr_line] = cur;
                    wr_pending = 1'b0;
                end
            end else if (mem_req_valid) begin
                line = int'(mem_req_addr[DL-1:0]);
                if (mem_req_rw) begin
                    wr_pending = 1'b1;
                    wr_line    = line;
                end else begin
                    cur = model_mem.exists(line) ? model_mem[line] : '0;
                    exp_q.push_back({32'(cyc + RL), mem_req_tag, cur});
                end
            end
        end
    end

    // Driver tasks: entered and left #1 after a rising edge.
    task automatic send_req(input logic rw, input logic [AB-1:0] addr, input logic [TW-1:0] tag);
        int k;
        mem_req_valid = 1'b1;
        mem_req_rw    = rw;
        mem_req_addr  = addr;
        mem_req_tag   = tag;
        k = 0;
        @(negedge clk);
        while (!mem_req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!mem_req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: got ready=0 required ready=1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        mem_req_valid = 1'b0;
    endtask

    task automatic send_data(input logic [DB-1:0] bits, input logic [MB-1:0] mask);
        int k;
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = bits;
        mem_req_data_mask  = mask;
        k = 0;
        @(negedge clk);
        while (!mem_req_data_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!mem_req_data_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL data_timeout: got data_ready=0 required data_ready=1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        mem_req_data_valid = 1'b0;
    endtask

    // Early data is presented alongside the request and must not be taken until WDATA.
    task automatic do_write(input logic [AB-1:0] addr, input logic [DB-1:0] bits,
                            input logic [MB-1:0] mask, input bit early);
        mem_req_data_bits = bits;
        mem_req_data_mask = mask;
        if (early) mem_req_data_valid = 1'b1;
        send_req(1'b1, addr, '0);
        send_data(bits, mask);
    endtask

    function automatic logic [DB-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [AB-1:0] addr;
        logic [MB-1:0] mask;
        int            r;
        int            n;

        reset              = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_tag        = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;

        // Reset held for three edges: everything quiet and zeroed.
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", DB'(mem_req_ready), '0);
        check("rst_data_ready", DB'(mem_req_data_ready), '0);
        check("rst_resp_valid", DB'(mem_resp_valid), '0);
        check("rst_resp_tag", DB'(mem_resp_tag), '0);
        check("rst_resp_data", mem_resp_data, '0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", DB'(mem_req_ready), DB'(1));
        @(posedge clk);
        #1;

        // Load lines 0..15 through the write port.
        for (int i = 0; i < 16; i++) do_write(AB'(i), rand_line(), '1, i[0]);
        do_write(AB'(5), LINE5, '1, 1'b0);
        do_write(AB'(7), LINE7, '1, 1'b1);

        // Read of a loaded line returns it with its tag after the latency.
        send_req(1'b0, AB'(5), TW'(3));
        repeat (RL - 1) @(posedge clk);
        @(negedge clk);
        check("rd5_valid", DB'(mem_resp_valid), DB'(1));
        check("rd5_tag", DB'(mem_resp_tag), DB'(3));
        check("rd5_data", mem_resp_data, LINE5);
        @(negedge clk);
        check("rd5_valid_drop", DB'(mem_resp_valid), '0);
        @(posedge clk);
        #1;

        // Masked write of the low half of line 7, then read it back immediately.
        send_req(1'b1, AB'(7), '0);
        @(negedge clk);
        check("wdata_req_ready", DB'(mem_req_ready), '0);
        @(posedge clk);
        #1;
        send_data('1, MB'(16'h00ff));
        send_req(1'b0, AB'(7), TW'(1));
        repeat (RL - 1) @(posedge clk);
        @(negedge clk);
        check("rd7_merged", mem_resp_data, LINE7_MERGED);
        @(posedge clk);
        #1;

        // Four back-to-back reads, tags 0..3, lines 4..7.
        for (int t = 0; t < 4; t++) begin
            mem_req_valid = 1'b1;
            mem_req_rw    = 1'b0;
            mem_req_addr  = AB'(4 + t);
            mem_req_tag   = TW'(t);
            @(posedge clk);
            #1;
        end
        mem_req_valid = 1'b0;
        repeat (RL - 1) @(posedge clk);
        @(negedge clk);
        check("burst_last_tag", DB'(mem_resp_tag), DB'(3));
        check("burst_last_data", mem_resp_data, LINE7_MERGED);
        @(posedge clk);
        #1;

        // Write abandoned by reset before its data beat; aliased address reads line 5.
        send_req(1'b1, AB'(5), '0);
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        mem_req_data_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("abandon_ready", DB'(mem_req_ready), DB'(1));
        @(posedge clk);
        #1;
        send_req(1'b0, AB'((1 << DL) + 5), TW'(9));
        repeat (RL - 1) @(posedge clk);
        @(negedge clk);
        check("alias_tag", DB'(mem_resp_tag), DB'(9));
        check("alias_data", mem_resp_data, LINE5);
        @(posedge clk);
        #1;

        // Random traffic against the model.
        for (int it = 0; it < 200; it++) begin
            r    = $urandom_range(0, 9);
            addr = AB'(($urandom_range(0, 3) << DL) | $urandom_range(0, 15));
            if (r < 4) begin
                send_req(1'b0, addr, TW'($urandom_range(0, 31)));
            end else if (r < 6) begin
                n = $urandom_range(2, 5);
                for (int k = 0; k < n; k++) begin
                    mem_req_valid = 1'b1;
                    mem_req_rw    = 1'b0;
                    mem_req_addr  = AB'(($urandom_range(0, 3) << DL) | $urandom_range(0, 15));
                    mem_req_tag   = TW'($urandom_range(0, 31));
                    @(posedge clk);
                    #1;
                end
                mem_req_valid = 1'b0;
            end else if (r < 8) begin
                mask = ($urandom_range(0, 3) == 0) ? '0 : MB'($urandom);
                do_write(addr, rand_line(), mask, bit'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1) send_req(1'b0, addr, TW'($urandom_range(0, 31)));
            end else if (r == 8) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end else begin
                send_req(1'b1, addr, '0);
                reset = 1'b0;
                @(posedge clk);
                #1;
                reset = 1'b1;
            end
        end

        // Drain and report.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", DB'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
